// File: rtl/reg_bank_lanes.sv
// Mixed scalar/vector register bank with lane-masked writes, write-to-read bypass,
// a pending-write scoreboard and a multi-cycle hardware clear sweep.
module reg_bank_lanes #(
  parameter int V  = 128,
  parameter int N  = 32,
  parameter int M  = 5,
  parameter int NS = 24,
  parameter int NV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we3,
  input  logic [M-1:0]     wa3,
  input  logic [V-1:0]     wd3,
  input  logic [V/N-1:0]   wmask,
  input  logic [M-1:0]     ra1,
  input  logic [M-1:0]     ra2,
  output logic [V-1:0]     rd1,
  output logic [V-1:0]     rd2,
  input  logic             rsv_en,
  input  logic [M-1:0]     rsv_addr,
  output logic             busy1,
  output logic             busy2,
  input  logic             clr_req,
  output logic             clr_busy
);

  localparam int L  = V / N;
  localparam int NR = NS + NV;
  localparam logic [M-1:0] LAST = M'(NR - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t         state;
  logic [M-1:0]   k;
  logic [N-1:0]   sregs [NS];
  logic [V-1:0]   vregs [NV];
  logic [NR-1:0]  sb;

  logic           idle;
  logic           wr_en;
  logic           rsv_ok;
  logic [V-1:0]   wr_old;
  logic [V-1:0]   wr_val;

  function automatic logic addr_valid(input logic [M-1:0] a);
    return {1'b0, a} < (M+1)'(NR);
  endfunction

  function automatic logic addr_scalar(input logic [M-1:0] a);
    return {1'b0, a} < (M+1)'(NS);
  endfunction

  // Scalars come back zero-extended; addresses beyond the bank read as zero.
  function automatic logic [V-1:0] read_reg(input logic [M-1:0] a);
    logic [V-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++)
      if (a == M'(i)) r = V'(sregs[i]);
    for (int j = 0; j < NV; j++)
      if (a == M'(NS + j)) r = vregs[j];
    return r;
  endfunction

  function automatic logic read_sb(input logic [M-1:0] a);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NR; i++)
      if (a == M'(i)) b = sb[i];
    return b;
  endfunction

  assign idle   = (state == IDLE);
  assign wr_en  = idle && we3 && addr_valid(wa3);
  assign rsv_ok = idle && rsv_en && addr_valid(rsv_addr);

  // Post-write value of the target register, shared by the write path and the bypass.
  always_comb begin
    wr_old = read_reg(wa3);
    wr_val = wr_old;
    if (addr_scalar(wa3)) begin
      wr_val = V'(wd3[N-1:0]);
    end else begin
      for (int i = 0; i < L; i++)
        if (wmask[i]) wr_val[i*N +: N] = wd3[i*N +: N];
    end
  end

  assign rd1 = (wr_en && (wa3 == ra1)) ? wr_val : read_reg(ra1);
  assign rd2 = (wr_en && (wa3 == ra2)) ? wr_val : read_reg(ra2);

  // A same-cycle write retires the pending producer unless a new one is reserved at once.
  assign busy1 = read_sb(ra1) &&
                 !(wr_en && (wa3 == ra1) && !(rsv_ok && (rsv_addr == ra1)));
  assign busy2 = read_sb(ra2) &&
                 !(wr_en && (wa3 == ra2) && !(rsv_ok && (rsv_addr == ra2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= SWEEP;
            k        <= '0;
            clr_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (k == LAST) begin
            state    <= IDLE;
            k        <= '0;
            clr_busy <= 1'b0;
          end else begin
            k <= k + M'(1);
          end
        end
        default: begin
          state    <= IDLE;
          k        <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // In SWEEP all external requests are dropped; only register k and its busy bit change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) sregs[i] <= '0;
      for (int j = 0; j < NV; j++) vregs[j] <= '0;
      sb <= '0;
    end else if (idle) begin
      for (int i = 0; i < NS; i++)
        if (wr_en && (wa3 == M'(i))) sregs[i] <= wd3[N-1:0];
      for (int j = 0; j < NV; j++)
        if (wr_en && (wa3 == M'(NS + j))) vregs[j] <= wr_val;
      for (int i = 0; i < NR; i++) begin
        if (wr_en && (wa3 == M'(i))) sb[i] <= 1'b0;
        if (rsv_ok && (rsv_addr == M'(i))) sb[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NS; i++)
        if (k == M'(i)) sregs[i] <= '0;
      for (int j = 0; j < NV; j++)
        if (k == M'(NS + j)) vregs[j] <= '0;
      for (int i = 0; i < NR; i++)
        if (k == M'(i)) sb[i] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_bank_lanes.sv
// Directed bench for reg_bank_lanes: stimulus queues expected values, a negedge
// monitor pops and compares them against the default bank and a 31-register variant.
module tb_reg_bank_lanes;

   logic         clk = 1'b0;
   logic         rst;
   logic         we3;
   logic [4:0]   wa3;
   logic [127:0] wd3;
   logic [3:0]   wmask;
   logic [4:0]   ra1, ra2;
   logic         rsv_en;
   logic [4:0]   rsv_addr;
   logic         clr_req;

   logic [127:0] rd1, rd2, rd1_7, rd2_7;
   logic         busy1, busy2, clr_busy;
   logic         busy1_7, busy2_7, clr_busy_7;

   localparam int SEL_RD1      = 0;
   localparam int SEL_RD2      = 1;
   localparam int SEL_BUSY1    = 2;
   localparam int SEL_BUSY2    = 3;
   localparam int SEL_CLR_BUSY = 4;
   localparam int SEL_RD1_7    = 5;
   localparam int SEL_BUSY1_7  = 6;

   typedef struct {
      string        name;
      int           sel;
      logic [127:0] value;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   logic [127:0] mon_act;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   reg_bank_lanes #(.V(128), .N(32), .M(5), .NS(24), .NV(8)) dut (
      .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .wmask(wmask),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2),
      .clr_req(clr_req), .clr_busy(clr_busy)
   );

   reg_bank_lanes #(.V(128), .N(32), .M(5), .NS(24), .NV(7)) dut7 (
      .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .wmask(wmask),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_7), .rd2(rd2_7),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1_7), .busy2(busy2_7),
      .clr_req(clr_req), .clr_busy(clr_busy_7)
   );

   // Queue an expectation for the negedge monitor.
   task automatic push_exp(input string name, input int sel, input logic [127:0] value);
      exp_t e;
      e.name  = name;
      e.sel   = sel;
      e.value = value;
      exp_q.push_back(e);
   endtask

   // Advance to just after the next rising edge with request inputs deasserted.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      we3     = 1'b0;
      rsv_en  = 1'b0;
      clr_req = 1'b0;
   endtask

   // Immediate comparison of a sampled value against its expectation.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Pop every queued expectation at the falling edge and compare it.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         case (mon_e.sel)
            SEL_RD1:      mon_act = rd1;
            SEL_RD2:      mon_act = rd2;
            SEL_BUSY1:    mon_act = 128'(busy1);
            SEL_BUSY2:    mon_act = 128'(busy2);
            SEL_CLR_BUSY: mon_act = 128'(clr_busy);
            SEL_RD1_7:    mon_act = rd1_7;
            SEL_BUSY1_7:  mon_act = 128'(busy1_7);
            default:      mon_act = 'x;
         endcase
         checks++;
         if (mon_act !== mon_e.value) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.value);
         end
      end
   end

   // Watchdog against a hung simulation.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   // Main directed stimulus sequence following the test plan.
   initial begin
      logic [127:0] merged;
      logic [127:0] w31;
      logic [31:0]  f;

      rst = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; wmask = '0;
      ra1 = 5'd3; ra2 = 5'd0; rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
      merged = 128'h11111111_AAAAAAAA_33333333_AAAAAAAA;
      w31    = 128'hCAFEF00D_01234567_89ABCDEF_FEDCBA98;

      applyStimulus();
      push_exp("reset_rd1", SEL_RD1, '0);
      push_exp("reset_clr_busy", SEL_CLR_BUSY, '0);
      push_exp("reset_busy1", SEL_BUSY1, '0);
      applyStimulus();
      rst = 1'b1;

      applyStimulus();
      we3 = 1'b1; wa3 = 5'd3; wd3 = {{3{32'hFFFFFFFF}}, 32'hDEADBEEF}; wmask = 4'h0;
      ra1 = 5'd3; ra2 = 5'd0;
      push_exp("scalar_bypass", SEL_RD1, {96'b0, 32'hDEADBEEF});
      push_exp("scalar_ra2_zero", SEL_RD2, '0);
      applyStimulus();
      push_exp("scalar_stored", SEL_RD1, {96'b0, 32'hDEADBEEF});
      #1;
      if (rd1 !== {96'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL direct_scalar_stored: got %h", rd1);
      end
      checks++;

      applyStimulus();
      we3 = 1'b1; wa3 = 5'd25; wd3 = 128'h11111111_22222222_33333333_44444444; wmask = 4'hF;
      ra1 = 5'd25;
      push_exp("vec_full_bypass", SEL_RD1, 128'h11111111_22222222_33333333_44444444);
      applyStimulus();
      we3 = 1'b1; wa3 = 5'd25; wd3 = {4{32'hAAAAAAAA}}; wmask = 4'b0101;
      push_exp("vec_mask_bypass", SEL_RD1, merged);
      applyStimulus();
      ra2 = 5'd25;
      push_exp("vec_mask_stored_rd1", SEL_RD1, merged);
      push_exp("vec_mask_stored_rd2", SEL_RD2, merged);
      #1;
      if (rd2 !== merged) begin
         errors++;
         $display("[TB] FAIL direct_vec_mask_rd2: got %h", rd2);
      end
      checks++;
      applyStimulus();
      we3 = 1'b1; wa3 = 5'd25; wd3 = {4{32'h55555555}}; wmask = 4'h0;
      push_exp("vec_mask0_bypass", SEL_RD1, merged);
      applyStimulus();
      push_exp("vec_mask0_stored", SEL_RD1, merged);

      applyStimulus();
      rsv_en = 1'b1; rsv_addr = 5'd30; ra1 = 5'd30;
      push_exp("rsv_same_cycle", SEL_BUSY1, '0);
      applyStimulus();
      ra2 = 5'd29;
      push_exp("rsv_next", SEL_BUSY1, 128'd1);
      push_exp("rsv_other_addr", SEL_BUSY2, '0);
      #1;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL direct_rsv_next: got %b", busy1);
      end
      checks++;
      applyStimulus();
      we3 = 1'b1; wa3 = 5'd30; wd3 = {4{32'h30303030}}; wmask = 4'hF;
      push_exp("wr_clear_bypass", SEL_BUSY1, '0);
      applyStimulus();
      push_exp("wr_clear_after", SEL_BUSY1, '0);
      applyStimulus();
      rsv_en = 1'b1; rsv_addr = 5'd30;
      applyStimulus();
      push_exp("rsv_again", SEL_BUSY1, 128'd1);
      applyStimulus();
      we3 = 1'b1; wa3 = 5'd30; rsv_en = 1'b1; rsv_addr = 5'd30;
      push_exp("rsv_wr_same_cycle", SEL_BUSY1, 128'd1);
      applyStimulus();
      push_exp("rsv_wins_after", SEL_BUSY1, 128'd1);

      // Address 31 is the last vector in the 32-register bank but invalid with NV=7.
      applyStimulus();
      we3 = 1'b1; wa3 = 5'd31; wd3 = w31; wmask = 4'hF; ra1 = 5'd31;
      rsv_en = 1'b1; rsv_addr = 5'd31;
      push_exp("a31_bypass", SEL_RD1, w31);
      push_exp("nv7_a31_bypass", SEL_RD1_7, '0);
      applyStimulus();
      push_exp("a31_stored", SEL_RD1, w31);
      push_exp("a31_busy", SEL_BUSY1, 128'd1);
      push_exp("nv7_a31_stored", SEL_RD1_7, '0);
      push_exp("nv7_a31_busy", SEL_BUSY1_7, '0);

      for (int a = 0; a < 32; a++) begin
         applyStimulus();
         f = 32'h10000000 + 32'(a);
         we3 = 1'b1; wa3 = 5'(a); wd3 = {4{f}}; wmask = 4'hF;
         rsv_en = 1'b1; rsv_addr = 5'(a);
      end
      applyStimulus();
      ra1 = 5'd3; ra2 = 5'd26;
      push_exp("fill_scalar", SEL_RD1, {96'b0, 32'h10000003});
      push_exp("fill_vector", SEL_RD2, {4{32'h1000001A}});
      push_exp("fill_busy", SEL_BUSY1, 128'd1);

      applyStimulus();
      clr_req = 1'b1;
      push_exp("clr_pulse_cycle", SEL_CLR_BUSY, '0);
      for (int c = 0; c < 32; c++) begin
         applyStimulus();
         push_exp("sweep_busy", SEL_CLR_BUSY, 128'd1);
         if (c == 5) begin
            we3 = 1'b1; wa3 = 5'd31; wd3 = '1; wmask = 4'hF;
            rsv_en = 1'b1; rsv_addr = 5'd2; clr_req = 1'b1;
            ra1 = 5'd31; ra2 = 5'd0;
            push_exp("sweep_no_bypass", SEL_RD1, {4{32'h1000001F}});
            push_exp("sweep_zeroed_read", SEL_RD2, '0);
         end
      end
      applyStimulus();
      push_exp("sweep_done", SEL_CLR_BUSY, '0);
      #1;
      if (clr_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL direct_sweep_done: got %b", clr_busy);
      end
      checks++;
      for (int a = 0; a < 32; a++) begin
         applyStimulus();
         ra1 = 5'(a); ra2 = 5'(31 - a);
         push_exp("post_sweep_rd1", SEL_RD1, '0);
         push_exp("post_sweep_busy1", SEL_BUSY1, '0);
         push_exp("post_sweep_busy2", SEL_BUSY2, '0);
         push_exp("post_sweep_idle", SEL_CLR_BUSY, '0);
      end

      applyStimulus();
      we3 = 1'b1; wa3 = 5'd25; wd3 = {4{32'h77777777}}; wmask = 4'hF;
      applyStimulus();
      clr_req = 1'b1;
      for (int c = 0; c < 10; c++) begin
         applyStimulus();
         push_exp("rst_sweep_busy", SEL_CLR_BUSY, 128'd1);
      end
      applyStimulus();
      ra1 = 5'd25;
      #2;
      rst = 1'b0;
      push_exp("async_rst_clr_busy", SEL_CLR_BUSY, '0);
      push_exp("async_rst_rd", SEL_RD1, '0);
      applyStimulus();
      rst = 1'b1;
      applyStimulus();
      we3 = 1'b1; wa3 = 5'd7; wd3 = 128'h0000_0000_0000_0000_0000_0000_1234_5678; wmask = 4'hF;
      ra1 = 5'd7;
      push_exp("post_rst_bypass", SEL_RD1, {96'b0, 32'h12345678});
      applyStimulus();
      push_exp("post_rst_stored", SEL_RD1, {96'b0, 32'h12345678});
      push_exp("post_rst_idle", SEL_CLR_BUSY, '0);
      #1;
      checkOutput("direct_post_rst_stored", rd1, {96'b0, 32'h12345678});

      @(negedge clk);
      #1;
      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bank_lanes.md
Name: reg_bank_lanes

Overview:
- Parametrised successor to the processor's mixed scalar/vector register bank.
- Shared address space: scalar registers at low addresses, vector registers above them.
- Adds per-lane masked vector writes, write-to-read bypass, a pending-write scoreboard for long-latency units, and a multi-cycle hardware clear sweep.
- Sits between decode (read ports, reservations) and writeback (write port).

Parameters:
- V, 128, vector register width in bits
- N, 32, scalar register width and lane width; V must be a multiple of N
- M, 5, register address width
- NS, 24, number of scalar registers (addresses 0..NS-1)
- NV, 8, number of vector registers (addresses NS..NS+NV-1); NS+NV <= 2^M
- L, V/N (derived, localparam), lane count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- we3  in  1  write enable
- wa3  in  M  write address
- wd3  in  V  write data; scalar writes use wd3[N-1:0]
- wmask  in  L  lane write enables, lane i = bits [i*N+N-1:i*N]; vector writes only
- ra1, ra2  in  M  read addresses
- rd1, rd2  out  V  read data
- rsv_en  in  1  reserve destination (mark pending)
- rsv_addr  in  M  address to reserve
- busy1, busy2  out  1  pending-write flag for ra1/ra2
- clr_req  in  1  start clear sweep (one-cycle pulse)
- clr_busy  out  1  sweep in progress

Behaviour:
- Reset (rst=0, async): all scalar and vector registers = 0, scoreboard = 0, FSM = IDLE, clr_busy = 0. Reads therefore return 0.
- Address decode: a < NS selects scalar a. NS <= a < NS+NV selects vector a-NS. Any higher address is invalid.
- Writes (IDLE only, we3=1, posedge):
  - Scalar target: rf <= wd3[N-1:0]; wmask ignored.
  - Vector target: only lanes with wmask[i]=1 updated; wmask=0 is a no-op. Invalid wa3: no state change.
- Reads (combinational): scalar data zero-extended to V; invalid address returns 0.
- Bypass: if we3=1 in IDLE and wa3==raX (valid), rdX returns the post-write value in the same cycle.
  - Scalar: zero-extended wd3[N-1:0].
  - Vector: per lane, wd3 where wmask=1, else stored lane.
- Scoreboard, one bit per valid address:
  - rsv_en=1 sets bit at posedge.
  - we3=1 clears bit of wa3 at posedge, regardless of wmask.
  - Same address, same cycle, both rsv_en and we3: set wins (new producer in flight).
  - busyX = bit[raX], forced 0 when a same-cycle write to raX clears it and no same-address reservation occurs. Invalid raX gives busyX = 0.
  - Invalid rsv_addr is ignored.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req=1; counter k = 0.
  - In SWEEP, each cycle zeroes register k and its scoreboard bit, then k++. After k = NS+NV-1 is zeroed -> IDLE.
  - Sweep length is exactly NS+NV cycles; clr_busy = 1 for exactly those cycles.
  - In SWEEP: we3, rsv_en and clr_req are ignored and dropped; bypass disabled; reads return current contents (already-zeroed or not-yet-zeroed).
  - clr_req in the same cycle as we3 in IDLE: the write is performed, then the sweep starts next cycle.
  - Reset mid-sweep: immediate return to IDLE, all state 0.

Test Plan:
- Reset, then write scalar 3 = 0xDEADBEEF, read ra1=3 -> rd1 = {96'b0, 32'hDEADBEEF}; read ra2=0 -> 0.
- Vector 25 (index 1) holds 0x11111111_22222222_33333333_44444444; write wd3 = all 0xAAAAAAAA with wmask=4'b0101 -> 0x11111111_AAAAAAAA_33333333_AAAAAAAA. Same-cycle read ra1=25 shows the merged value via bypass.
- rsv_en at addr 30 -> busy1 = 1 for ra1=30 next cycle. Write 30 -> busy1 = 0 in the write cycle (bypass) and after. Reserve and write 30 in the same cycle -> busy1 stays 1.
- Write to addr 31 with NS+NV=32 succeeds. With NV=7, write to 31 -> no change, read 31 -> 0, busy 0.
- Fill all registers nonzero, pulse clr_req -> clr_busy high exactly 32 cycles. A we3 issued mid-sweep is dropped. Afterwards all reads = 0 and all busy = 0.
- Assert rst=0 at sweep cycle 10 asynchronously -> clr_busy = 0 immediately, all registers 0. After release, normal writes work.
